mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 16-bit 4:1 select mux among four requesters in the multicycle datapath, such as PC logic, ALU, memory read and register writeback sources.
It drives the mux 2-bit select `sbit` and a one-hot grant vector.
It bounds each owner's tenure with a hold limit so that no requester can starve the others.
The mux itself stays purely combinational; all sequencing lives in this block.

---
 rtl/mux4_rr_arbiter_if.sv | 40 ++++
 rtl/mux4_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter_if
// Bundles the request/grant signals between the four datapath requesters and
// the round-robin arbiter that owns the shared 16-bit 4:1 select mux.
//
//   req       4      request lines, bit i = requester i (mux input in(i+1))
//   gnt       4      registered one-hot grant, zero when nobody owns the mux
//   sbit      2      registered mux select, current or most recent owner
//   bus_valid 1      high while gnt is non-zero
//   hold_cnt  CNT_W  cycles the current owner has held the grant, minus 1
//
// Modports:
//   master : requester side (drives req, observes the grant outputs)
//   slave  : arbiter side   (samples req, drives the grant outputs)
// -----------------------------------------------------------------------------
interface mux4_rr_arbiter_if #(
   parameter int CNT_W = 4
);
   logic [3:0]       req;
   logic [3:0]       gnt;
   logic [1:0]       sbit;
   logic             bus_valid;
   logic [CNT_W-1:0] hold_cnt;

   modport master (
      output req,
      input  gnt,
      input  sbit,
      input  bus_valid,
      input  hold_cnt
   );

   modport slave (
      input  req,
      output gnt,
      output sbit,
      output bus_valid,
      output hold_cnt
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter that shares one combinational 16-bit 4:1 select mux
// among four requesters (PC logic, ALU, memory read, register writeback).
// It drives the mux select and a one-hot grant. Each owner's tenure is bounded
// by MAX_HOLD cycles whenever another requester is waiting, so nobody starves.
//
// Ports:
//   clk    input   single system clock, rising edge
//   rst_n  input   synchronous active-low reset
//   bus    slave   req in; gnt, sbit, bus_valid, hold_cnt out (all registered)
//
// Parameters:
//   MAX_HOLD  maximum consecutive cycles one owner keeps the grant while
//             another requester waits (2..15)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input logic               clk,
   input logic               rst_n,
   mux4_rr_arbiter_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state_reg;
   logic [1:0]       ptr_reg;
   logic [3:0]       gnt_reg;
   logic [1:0]       sbit_reg;
   logic             bus_valid_reg;
   logic [CNT_W-1:0] hold_cnt_reg;

   logic             own;
   logic             owner_req;
   logic             at_limit;
   logic [3:0]       cand;
   logic [3:0]       rot;
   logic             found;
   logic [1:0]       win_off;
   logic [1:0]       win;

   assign own       = (state_reg == OWN);
   assign owner_req = bus.req[sbit_reg];
   assign at_limit  = (hold_cnt_reg == HOLD_LAST);

   // Candidate set: every requester except the present owner. In IDLE there
   // is no owner, so all requests compete. On a release the owner's bit is
   // already low, so the same mask serves both release and timeout.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cand
         assign cand[gi] = bus.req[gi] & ~(own && (sbit_reg == 2'(gi)));
      end
   endgenerate

   // Rotate the candidates so that rot[0] is the requester at ptr; the search
   // then becomes a plain lowest-bit-first priority encode.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rot
         logic [1:0] idx;
         assign idx     = ptr_reg + 2'(gi);
         assign rot[gi] = cand[idx];
      end
   endgenerate

   always_comb begin
      found   = |rot;
      win_off = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (rot[i]) begin
            win_off = 2'(i);
         end
      end
      win = ptr_reg + win_off;
   end

   // Single registered FSM. sbit is only written when a new owner is granted,
   // so it holds the last owner through IDLE and the mux select never moves
   // while nothing is being driven.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         ptr_reg       <= 2'd0;
         gnt_reg       <= 4'b0000;
         sbit_reg      <= 2'd0;
         bus_valid_reg <= 1'b0;
         hold_cnt_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (found) begin
                  state_reg     <= OWN;
                  gnt_reg       <= 4'b0001 << win;
                  sbit_reg      <= win;
                  bus_valid_reg <= 1'b1;
                  hold_cnt_reg  <= '0;
                  ptr_reg       <= win + 2'd1;
               end
            end

            OWN: begin
               if (!owner_req) begin
                  // Release: hand over directly when someone is waiting,
                  // avoiding an idle bubble between owners.
                  if (found) begin
                     gnt_reg       <= 4'b0001 << win;
                     sbit_reg      <= win;
                     hold_cnt_reg  <= '0;
                     ptr_reg       <= win + 2'd1;
                  end else begin
                     state_reg     <= IDLE;
                     gnt_reg       <= 4'b0000;
                     bus_valid_reg <= 1'b0;
                     hold_cnt_reg  <= '0;
                  end
               end else if (at_limit) begin
                  // Tenure exhausted: force a switch if anyone else waits,
                  // otherwise the owner keeps the bus and the count wraps.
                  if (found) begin
                     gnt_reg       <= 4'b0001 << win;
                     sbit_reg      <= win;
                     ptr_reg       <= win + 2'd1;
                  end
                  hold_cnt_reg  <= '0;
               end else begin
                  hold_cnt_reg  <= hold_cnt_reg + 1'b1;
               end
            end

            default: begin
               state_reg     <= IDLE;
               gnt_reg       <= 4'b0000;
               bus_valid_reg <= 1'b0;
               hold_cnt_reg  <= '0;
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_reg;
   assign bus.sbit      = sbit_reg;
   assign bus.bus_valid = bus_valid_reg;
   assign bus.hold_cnt  = hold_cnt_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Directed vectors with hand-computed expectations. The stimulus process
// applies one input vector per clock and queues the output expected after
// that edge; a separate monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

   typedef struct {
      string      name;
      logic [3:0] gnt;
      logic [1:0] sbit;
      logic       bv;
      logic [3:0] hc;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t exp_q[$];
   int   n_checks;
   int   n_pass;
   bit   stim_done;

   mux4_rr_arbiter_if #(.CNT_W(4)) bif ();

   mux4_rr_arbiter #(
      .MAX_HOLD (8),
      .CNT_W    (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one vector, let one rising edge pass, then queue what the outputs
   // must be after that edge.
   task automatic step(input string nm, input logic r, input logic [3:0] q,
                       input logic [3:0] g, input logic [1:0] s,
                       input logic b, input logic [3:0] h);
      exp_t e;
      rst_n   = r;
      bif.req = q;
      @(posedge clk);
      e.name = nm; e.gnt = g; e.sbit = s; e.bv = b; e.hc = h;
      exp_q.push_back(e);
      #1;
   endtask

   // Monitor: one comparison per completed clock edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bif.gnt === e.gnt && bif.sbit === e.sbit &&
                bif.bus_valid === e.bv && bif.hold_cnt === e.hc) begin
               n_pass++;
               $display("ok   %-10s gnt=%b sbit=%0d bv=%b hc=%0d",
                        e.name, bif.gnt, bif.sbit, bif.bus_valid, bif.hold_cnt);
            end else begin
               $display("FAIL %s: got gnt=%b sbit=%0d bv=%b hc=%0d, want gnt=%b sbit=%0d bv=%b hc=%0d",
                        e.name, bif.gnt, bif.sbit, bif.bus_valid, bif.hold_cnt,
                        e.gnt, e.sbit, e.bv, e.hc);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: stimulus not done, want done");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      stim_done = 0;
      rst_n     = 1'b0;
      bif.req   = 4'b0000;

      // Reset and idle: nothing granted, sbit at 0.
      step("reset", 0, 4'b0000, 4'b0000, 2'd0, 0, 4'd0);
      step("reset", 0, 4'b0000, 4'b0000, 2'd0, 0, 4'd0);
      for (int k = 0; k < 5; k++)
         step("idle", 1, 4'b0000, 4'b0000, 2'd0, 0, 4'd0);

      // Single requester 2: one-cycle latency, sbit held after release.
      step("single", 1, 4'b0100, 4'b0100, 2'd2, 1, 4'd0);
      step("single", 1, 4'b0100, 4'b0100, 2'd2, 1, 4'd1);
      step("single", 1, 4'b0100, 4'b0100, 2'd2, 1, 4'd2);
      step("release", 1, 4'b0000, 4'b0000, 2'd2, 0, 4'd0);
      step("sbit_keep", 1, 4'b0000, 4'b0000, 2'd2, 0, 4'd0);
      // ptr is now 3; requester 2 is still the only candidate.
      step("regrant", 1, 4'b0100, 4'b0100, 2'd2, 1, 4'd0);
      step("rst_mid", 0, 4'b0100, 4'b0000, 2'd0, 0, 4'd0);

      // All four requesting, each owner drops after two granted cycles.
      step("rr0", 1, 4'b1111, 4'b0001, 2'd0, 1, 4'd0);
      step("rr0", 1, 4'b1111, 4'b0001, 2'd0, 1, 4'd1);
      step("rr1", 1, 4'b1110, 4'b0010, 2'd1, 1, 4'd0);
      step("rr1", 1, 4'b1111, 4'b0010, 2'd1, 1, 4'd1);
      step("rr2", 1, 4'b1101, 4'b0100, 2'd2, 1, 4'd0);
      step("rr2", 1, 4'b1111, 4'b0100, 2'd2, 1, 4'd1);
      step("rr3", 1, 4'b1011, 4'b1000, 2'd3, 1, 4'd0);
      step("rr3", 1, 4'b1111, 4'b1000, 2'd3, 1, 4'd1);
      step("rr0_again", 1, 4'b0111, 4'b0001, 2'd0, 1, 4'd0);
      step("reset", 0, 4'b0000, 4'b0000, 2'd0, 0, 4'd0);

      // Owner 1 held, requester 3 waiting from cycle 2: 8-cycle tenure.
      step("hold", 1, 4'b0010, 4'b0010, 2'd1, 1, 4'd0);
      step("hold", 1, 4'b0010, 4'b0010, 2'd1, 1, 4'd1);
      for (int k = 2; k < 8; k++)
         step("hold", 1, 4'b1010, 4'b0010, 2'd1, 1, 4'(k));
      step("timeout", 1, 4'b1010, 4'b1000, 2'd3, 1, 4'd0);
      step("after_to", 1, 4'b1010, 4'b1000, 2'd3, 1, 4'd1);
      step("reset", 0, 4'b0000, 4'b0000, 2'd0, 0, 4'd0);

      // Lone requester 0 for 20 cycles: counter wraps, grant never drops.
      for (int k = 0; k < 20; k++)
         step("wrap", 1, 4'b0001, 4'b0001, 2'd0, 1, 4'(k % 8));
      step("reset", 0, 4'b0000, 4'b0000, 2'd0, 0, 4'd0);

      // Owner 1 (ptr=2) releases while 3 and 0 wait: 3 wins, ptr becomes 0.
      step("ptr_setup", 1, 4'b0010, 4'b0010, 2'd1, 1, 4'd0);
      step("ptr_wrap", 1, 4'b1001, 4'b1000, 2'd3, 1, 4'd0);
      step("ptr_wrap", 1, 4'b1001, 4'b1000, 2'd3, 1, 4'd1);
      step("ptr_zero", 1, 4'b0001, 4'b0001, 2'd0, 1, 4'd0);
      step("ptr_one", 1, 4'b0110, 4'b0010, 2'd1, 1, 4'd0);
      step("to_idle", 1, 4'b0000, 4'b0000, 2'd1, 0, 4'd0);

      @(negedge clk);
      @(negedge clk);
      stim_done = 1;
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
